program_loader: RTL and testbench

Boot-time loader sitting directly upstream of the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and drives the instruction memory write port (address, data, write enable) sequentially from address 0. Holds the CPU in reset via `cpu_hold` until a complete, checksum-verified program is in memory.

---
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time loader that receives a length-prefixed byte stream,
// assembles 16-bit words, writes them into instruction memory from address 0,
// verifies a trailing XOR checksum and releases the CPU only on success.
module program_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_SIZE   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // One extra bit so a 16-bit length can be compared against the depth unambiguously.
    localparam logic [16:0] MaxWords = 17'(MEM_SIZE);

    state_t      state;
    state_t      state_next;
    logic [15:0] word_len;
    logic [15:0] word_cnt;
    logic [7:0]  hi_byte;
    logic [7:0]  run_xor;
    logic        xfer;

    // byte_ready is a registered decode of the state, so this carries no input-to-output path.
    assign xfer = byte_valid & byte_ready;

    // Next-state decision; outputs are registered from this in the sequential block.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, word_len[15:8], byte_in} > MaxWords) state_next = S_ERROR;
                    else if ({word_len[15:8], byte_in} == 16'd0)    state_next = S_CHECK;
                    else                                            state_next = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer) state_next = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (xfer) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (word_cnt + 16'd1 == word_len) state_next = S_CHECK;
                else                              state_next = S_DATA_HI;
            end
            S_CHECK: begin
                if (xfer) state_next = (byte_in == run_xor) ? S_DONE : S_ERROR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register, registered Moore outputs and the datapath (length, counters, checksum, write data).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_len   <= '0;
            word_cnt   <= '0;
            hi_byte    <= '0;
            run_xor    <= '0;
        end else begin
            state      <= state_next;
            byte_ready <= state_next inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
            mem_we     <= (state_next == S_WRITE);
            done       <= (state_next == S_DONE);
            error      <= (state_next == S_ERROR);
            cpu_hold   <= (state_next != S_DONE);

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        mem_addr <= '0;
                        word_cnt <= '0;
                        run_xor  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        word_len[15:8] <= byte_in;
                        run_xor        <= run_xor ^ byte_in;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        word_len[7:0] <= byte_in;
                        run_xor       <= run_xor ^ byte_in;
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= byte_in;
                        run_xor <= run_xor ^ byte_in;
                    end
                end
                S_DATA_LO: begin
                    if (xfer) begin
                        mem_data <= {hi_byte, byte_in};
                        run_xor  <= run_xor ^ byte_in;
                    end
                end
                S_WRITE: begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    word_cnt <= word_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads against a stream-level model of the loader
// (expected writes, verdict) with a per-cycle compare process on the write port.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_q[$];
    logic [15:0] exp_words[$];
    logic [31:0] front;
    int          exp_n;
    bit          exp_ok;
    bit          exp_overflow;
    logic [7:0]  exp_xor;
    logic [15:0] imem [0:1023];
    bit          checking = 1'b0;
    int          acc;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    program_loader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .MEM_SIZE  (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    // Stream-level model: word count, expected writes in order, checksum verdict.
    task automatic model_load();
        exp_q.delete();
        exp_words.delete();
        exp_n        = int'({stream[0], stream[1]});
        exp_xor      = stream[0] ^ stream[1];
        exp_overflow = (exp_n > 1024);
        exp_ok       = 1'b0;
        if (!exp_overflow) begin
            for (int w = 0; w < exp_n; w++) begin
                logic [15:0] wd;
                wd = {stream[2 + 2*w], stream[3 + 2*w]};
                exp_words.push_back(wd);
                exp_q.push_back({16'(w), wd});
                exp_xor = exp_xor ^ stream[2 + 2*w] ^ stream[3 + 2*w];
            end
            exp_ok = (stream[2 + 2*exp_n] == exp_xor);
        end
    endtask

    // Instruction memory as seen by the bench: captures on the edge that ends the write cycle.
    always @(posedge clk) begin
        if (mem_we && mem_addr < 16'd1024) imem[mem_addr[9:0]] <= mem_data;
    end

    // Per-cycle compare of the write port and status outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            check_output("done_error_exclusive", 32'(done & error), 32'd0);
            check_output("cpu_hold_vs_done", 32'(cpu_hold), 32'(!done));
            if (mem_we) begin
                check_output("ready_low_in_write", 32'(byte_ready), 32'd0);
                check_output("write_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    front = exp_q.pop_front();
                    check_output("write_addr", 32'(mem_addr), 32'(front[31:16]));
                    check_output("write_data", 32'(mem_data), 32'(front[15:0]));
                end
            end
        end
    end

    // Pulse start, then offer the stream byte by byte; optional random valid gaps,
    // valid always high while a write is in progress; optional stop after N writes.
    task automatic apply_stimulus(input bit gaps, input int stop_writes, output int accepted);
        int idx    = 0;
        int budget = 0;
        int writes = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("ready_after_start", 32'(byte_ready), 32'd1);
        while (idx < stream.size()) begin
            if (budget > 5000) begin
                check_output("load_timeout", 32'(budget), 32'd0);
                break;
            end
            if (error) break;
            if (mem_we) writes++;
            if (stop_writes > 0 && writes >= stop_writes && !mem_we) break;
            if (gaps && !mem_we && $urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = stream[idx];
            end
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
            budget++;
        end
        byte_valid = 1'b0;
        accepted   = idx;
    endtask

    // Full load: model, drive, then verdict, leftover writes and memory image.
    task automatic run_load(input string tag, input bit gaps);
        int got;
        model_load();
        for (int i = 0; i < 1024; i++) imem[i] = 16'hDEAD;
        apply_stimulus(gaps, 0, got);
        check_output({tag, "_done"},     32'(done),     32'(exp_ok));
        check_output({tag, "_error"},    32'(error),    32'(!exp_ok));
        check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_ok));
        if (exp_overflow) begin
            check_output({tag, "_accepted"}, 32'(got), 32'd2);
            byte_valid = 1'b1;
            byte_in    = 8'hAA;
            repeat (4) begin
                @(negedge clk);
                check_output({tag, "_ready_low"}, 32'(byte_ready), 32'd0);
            end
            byte_valid = 1'b0;
        end else begin
            check_output({tag, "_accepted"}, 32'(got), 32'(stream.size()));
        end
        check_output({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        for (int w = 0; w < exp_words.size(); w++)
            check_output({tag, "_mem"}, 32'(imem[w]), 32'(exp_words[w]));
    endtask

    // Directed sequence of loads.
    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        #12;
        check_output("rst_byte_ready", 32'(byte_ready), 32'd0);
        check_output("rst_mem_addr",   32'(mem_addr),   32'd0);
        check_output("rst_mem_data",   32'(mem_data),   32'd0);
        check_output("rst_mem_we",     32'(mem_we),     32'd0);
        check_output("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        check_output("rst_done",       32'(done),       32'd0);
        check_output("rst_error",      32'(error),      32'd0);
        @(negedge clk);
        rst      = 1'b1;
        checking = 1'b1;

        // Three words; the XOR of the eight header and data bytes is 0x42.
        stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h42};
        model_load();
        check_output("model_n",   32'(exp_n),   32'd3);
        check_output("model_xor", 32'(exp_xor), 32'h42);
        check_output("model_ok",  32'(exp_ok),  32'd1);
        run_load("basic", 1'b0);
        check_output("basic_word0", 32'(imem[0]), 32'h1234);
        check_output("basic_word1", 32'(imem[1]), 32'hABCD);
        check_output("basic_word2", 32'(imem[2]), 32'h0001);

        // Empty program.
        stream = '{8'h00, 8'h00, 8'h00};
        run_load("empty", 1'b0);

        // Wrong checksum, then a clean reload from the error state.
        stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h48};
        model_load();
        check_output("model_bad_ok", 32'(exp_ok), 32'd0);
        run_load("bad_chk", 1'b0);
        stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h42};
        run_load("recover", 1'b0);

        // Length one word beyond the memory depth.
        stream = '{8'h04, 8'h01, 8'h12, 8'h34, 8'hAB};
        model_load();
        check_output("model_n_overflow", 32'(exp_n), 32'd1025);
        run_load("overflow", 1'b0);

        // Same program with random valid gaps.
        stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h42};
        run_load("gaps", 1'b1);
        check_output("gaps_word1", 32'(imem[1]), 32'hABCD);

        // Reset in the middle of a load, after the second write.
        model_load();
        apply_stimulus(1'b0, 2, acc);
        check_output("pre_reset_addr", 32'(mem_addr), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_output("midrst_byte_ready", 32'(byte_ready), 32'd0);
        check_output("midrst_mem_addr",   32'(mem_addr),   32'd0);
        check_output("midrst_mem_data",   32'(mem_data),   32'd0);
        check_output("midrst_mem_we",     32'(mem_we),     32'd0);
        check_output("midrst_cpu_hold",   32'(cpu_hold),   32'd1);
        check_output("midrst_done",       32'(done),       32'd0);
        check_output("midrst_error",      32'(error),      32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        run_load("after_reset", 1'b0);

        checking = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
